// File: rtl/instruction_fetch_tag.sv
// instruction_fetch_tag: first front-end stage. Owns the fetch PC, the I$ tag
// RAM and the per-line valid bits. Issues one tag lookup per cycle and hands
// the PC, all way tags and valid bits to the fetch-data stage. Handles miss
// rollback, replay after refill, redirects and whole-cache invalidation.
//
// Ports:
//   clk               clock, all state on the rising edge
//   rst               asynchronous active-low reset
//   stall             hold PC and outputs
//   flush             drop the in-flight fetch (optionally with redirect)
//   pc_redirect_en    load pc_redirect (word aligned) as the next fetch PC
//   pc_redirect       redirect target
//   icache_invalidate clear every valid bit
//   ifd_ift_inf       {cache_miss, update_tag_en[WAYS], update_tag_set, update_tag}
//   ift_ifd_inf       {instruction_valid, fetched_pc[31:0], tags_read[WAYS*TAG], valid_bits[WAYS]}
//                     way w's tag sits at tags_read[w*TAG_WIDTH +: TAG_WIDTH]
module instruction_fetch_tag #(
  parameter int unsigned ICACHE_NUM_WAYS = 4,
  parameter int unsigned ICACHE_NUM_SETS = 64,
  parameter int unsigned ICACHE_CL_SIZE  = 64,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  localparam int unsigned SET_W     = $clog2(ICACHE_NUM_SETS),
  localparam int unsigned OFF_W     = $clog2(ICACHE_CL_SIZE),
  localparam int unsigned TAG_WIDTH = 32 - SET_W - OFF_W,
  localparam int unsigned IFD_W     = 1 + ICACHE_NUM_WAYS + SET_W + TAG_WIDTH,
  localparam int unsigned IFT_W     = 1 + 32 + ICACHE_NUM_WAYS * TAG_WIDTH + ICACHE_NUM_WAYS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             pc_redirect_en,
  input  logic [31:0]      pc_redirect,
  input  logic             icache_invalidate,
  input  logic [IFD_W-1:0] ifd_ift_inf,
  output logic [IFT_W-1:0] ift_ifd_inf
);

  typedef enum logic [1:0] {RUN, MISS_WAIT, REPLAY} state_t;

  state_t                          state_q;
  logic [31:0]                     pc_q;
  logic [31:0]                     fetched_pc_q;
  logic                            instr_valid_q;
  logic                            issue;
  logic [31:0]                     redirect_pc;
  logic [SET_W-1:0]                rd_set;

  logic                            cache_miss;
  logic [ICACHE_NUM_WAYS-1:0]      upd_en;
  logic [SET_W-1:0]                upd_set;
  logic [TAG_WIDTH-1:0]            upd_tag;

  logic [ICACHE_NUM_WAYS*TAG_WIDTH-1:0] tags_read_flat;
  logic [ICACHE_NUM_WAYS-1:0]           valid_bits_flat;

  // Unpack the feedback bus from the fetch-data stage.
  assign {cache_miss, upd_en, upd_set, upd_tag} = ifd_ift_inf;

  assign redirect_pc = pc_redirect & 32'hFFFF_FFFC;
  assign rd_set      = pc_q[OFF_W +: SET_W];

  // A lookup is issued from RUN (no miss reported) or from the REPLAY bubble.
  always_comb begin
    issue = 1'b0;
    if (!flush && !stall) begin
      case (state_q)
        RUN:     issue = !cache_miss;
        REPLAY:  issue = 1'b1;
        default: issue = 1'b0;
      endcase
    end
  end

  // Fetch FSM, PC and registered fetch outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      fetched_pc_q  <= RESET_PC;
      instr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (flush) begin
            instr_valid_q <= 1'b0;
            if (pc_redirect_en) pc_q <= redirect_pc;
          end else if (!stall && cache_miss) begin
            // Roll back to the PC that missed; fetched_pc keeps showing it.
            pc_q          <= fetched_pc_q;
            instr_valid_q <= 1'b0;
            state_q       <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          // Stall is ignored; a flush only retargets the PC for the replay.
          if (flush && pc_redirect_en) pc_q <= redirect_pc;
          if (|upd_en) state_q <= REPLAY;
        end
        REPLAY: begin
          if (flush) begin
            instr_valid_q <= 1'b0;
            if (pc_redirect_en) pc_q <= redirect_pc;
            state_q <= RUN;
          end else if (!stall) begin
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase

      if (issue) begin
        fetched_pc_q  <= pc_q;
        instr_valid_q <= 1'b1;
        pc_q          <= pc_q + 32'd4;
      end
    end
  end

  // Per-way tag RAM, valid flops and registered read port.
  for (genvar g = 0; g < ICACHE_NUM_WAYS; g++) begin : g_way
    logic [TAG_WIDTH-1:0]       mem [ICACHE_NUM_SETS];
    logic [ICACHE_NUM_SETS-1:0] vld;
    logic [TAG_WIDTH-1:0]       tag_rd_q;
    logic                       vld_rd_q;

    // Tag storage has no reset; refill writes land whenever enabled.
    always_ff @(posedge clk) begin
      if (upd_en[g]) mem[upd_set] <= upd_tag;
    end

    // Invalidate wins over a same-cycle refill valid-set.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld <= '0;
      end else if (icache_invalidate) begin
        vld <= '0;
      end else if (upd_en[g]) begin
        vld[upd_set] <= 1'b1;
      end
    end

    // Read address only advances on issue, so the read data is held otherwise.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        tag_rd_q <= '0;
        vld_rd_q <= 1'b0;
      end else if (issue) begin
        tag_rd_q <= mem[rd_set];
        vld_rd_q <= vld[rd_set];
      end
    end

    assign tags_read_flat[g*TAG_WIDTH +: TAG_WIDTH] = tag_rd_q;
    assign valid_bits_flat[g]                       = vld_rd_q;
  end

  assign ift_ifd_inf = {instr_valid_q, fetched_pc_q, tags_read_flat, valid_bits_flat};

endmodule
